muldiv_unit: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit implementing the RV32M operations at configurable width.
- Sits beside the combinational ALU in the execute stage; the control unit stalls the pipeline while `busy` is high.
- Uses a start/busy/valid handshake and an iterative radix-2 datapath: one bit per cycle, shift-add for multiply, restoring shift-subtract for divide.

---
 rtl/muldiv_unit_pkg.sv | 34 +++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared operation codes, FSM states and operand-signedness helpers for muldiv_unit.
package muldiv_unit_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFin  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input op_e op);
        return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic op_b_signed(input op_e op);
        return op inside {OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            div_mode_i,
    input  logic            in_bit_i,
    input  logic [XLEN-1:0] opnd_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (in_bit_i ? {1'b0, opnd_i} : '0);
        shifted = {hi_i, in_bit_i};
        diff    = shifted - {1'b0, opnd_i};
        if (div_mode_i) begin
            // diff[XLEN] set means the trial subtraction borrowed: restore
            if (!diff[XLEN]) begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shifted[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/valid handshake.
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and MUL* by zero in one cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN + 1);
    localparam int unsigned IdxW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN - 1){1'b0}}};

    state_e          state_q, state_d;
    op_e             op_q, op_d, op_in;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d, dz_q, dz_d, ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            accept, a_neg_in, b_neg_in, dz_in, ovf_in, early_in;
    logic [IdxW-1:0] div_idx;
    logic            step_bit;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, a_orig, fin_result;

    assign op_in    = op_e'(op);
    assign accept   = start && (state_q == StIdle);
    assign a_neg_in = op_a_signed(op_in) && a[XLEN-1];
    assign b_neg_in = op_b_signed(op_in) && b[XLEN-1];
    assign dz_in    = op_is_div(op_in) && (b == '0);
    assign ovf_in   = (op_in inside {OpDiv, OpRem}) && (a == MostNeg) && (b == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_in = dz_in || ovf_in || (!op_is_div(op_in) && (b == '0));
`else
    assign early_in = 1'b0;
`endif

    // Dividend bits are consumed MSB first, indexed by the remaining-iteration count
    assign div_idx  = IdxW'(cnt_q - CntW'(1));
    assign step_bit = op_is_div(op_q) ? a_q[div_idx] : b_q[0];

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .div_mode_i(op_is_div(op_q)),
        .in_bit_i  (step_bit),
        .opnd_i    (op_is_div(op_q) ? b_q : a_q),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .hi_o      (step_hi),
        .lo_o      (step_lo)
    );

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quo_fix  = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
        rem_fix  = a_neg_q ? -hi_q : hi_q;
        a_orig   = a_neg_q ? -a_q : a_q;
        unique case (op_q)
            OpMul:                     fin_result = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fin_result = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             fin_result = dz_q ? '1 : (ovf_q ? MostNeg : quo_fix);
            OpRem, OpRemu:             fin_result = dz_q ? a_orig : (ovf_q ? '0 : rem_fix);
            default:                   fin_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = early_in ? StFin : StCalc;
            StCalc:  if (cnt_q == CntW'(1)) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q != StIdle);
        valid  = valid_q;
        result = result_q;
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = 1'b0;
        if (accept) begin
            op_d    = op_in;
            a_d     = a_neg_in ? -a : a;
            b_d     = b_neg_in ? -b : b;
            a_neg_d = a_neg_in;
            b_neg_d = b_neg_in;
            dz_d    = dz_in;
            ovf_d   = ovf_in;
            hi_d    = '0;
            lo_d    = '0;
            cnt_d   = CntW'(XLEN);
        end else if (state_q == StCalc) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CntW'(1);
            if (!op_is_div(op_q)) b_d = b_q >> 1;
        end else if (state_q == StFin) begin
            result_d = fin_result;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q     <= OpMul;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=8.
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int unsigned SpecLat = 1;
    localparam int unsigned SpecLat8 = 1;
`else
    localparam int unsigned SpecLat = 33;
    localparam int unsigned SpecLat8 = 9;
`endif

    typedef struct {
        string       name;
        logic [31:0] res;
        int unsigned t0;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, start8;
    logic [2:0]  op, op8;
    logic [31:0] a, b, result;
    logic [7:0]  a8, b8, result8;
    logic        busy, valid, busy8, valid8;

    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    exp_t        exp_q[$];
    exp_t        exp8_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit #(.XLEN(32)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .valid(valid), .result(result)
    );

    muldiv_unit #(.XLEN(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .valid(valid8), .result(result8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_valid32: result %h with nothing outstanding", result);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_res"}, {32'h0, result}, {32'h0, e.res});
                check({e.name, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && valid8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_valid8: result %h with nothing outstanding", result8);
            end else begin
                e = exp8_q.pop_front();
                check({e.name, "_res"}, {56'h0, result8}, {32'h0, e.res});
                check({e.name, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] r, input int unsigned lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        e.name = nm; e.res = r; e.t0 = cyc + 1; e.lat = lat;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue8(input string nm, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] r, input int unsigned lat);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        e.name = nm; e.res = {24'h0, r}; e.t0 = cyc + 1; e.lat = lat;
        exp8_q.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0 || busy || busy8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            $display("FAIL %s_timeout: still waiting after %0d cycles, expected completion", nm, n);
            exp_q.delete();
            exp8_q.delete();
        end
    endtask

    initial begin
        int n;
        rstn = 1'b0; start = 1'b0; start8 = 1'b0;
        op = MUL; a = '0; b = '0; op8 = MUL; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_valid", {63'h0, valid}, 64'h0);
        check("rst_result", {32'h0, result}, 64'h0);
        check("rst_result8", {56'h0, result8}, 64'h0);
        rstn = 1'b1;

        // MUL with busy-duration check
        issue("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 64'(n), 64'd33);
        wait_done("mul");

        issue("mulh", MULH, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);      wait_done("mulh");
        issue("mulhsu", MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);  wait_done("mulhsu");
        issue("mulhu", MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33);    wait_done("mulhu");
        issue("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);                wait_done("div");
        issue("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);                wait_done("rem");
        issue("divu", DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);             wait_done("divu");
        issue("remu", REMU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 33);             wait_done("remu");

        // Special cases
        issue("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat); wait_done("div_ovf");
        issue("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SpecLat);         wait_done("rem_ovf");
        issue("divu_z", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat);                 wait_done("divu_z");
        issue("remu_z", REMU, 32'd5, 32'd0, 32'd5, SpecLat);                         wait_done("remu_z");
        issue("div_negz", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SpecLat);        wait_done("div_negz");
        issue("rem_negz", REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SpecLat);        wait_done("rem_negz");
        issue("mul_z", MUL, 32'h1234_5678, 32'd0, 32'd0, SpecLat);                   wait_done("mul_z");

        // start while busy must be ignored
        issue("ign", DIVU, 32'd100, 32'd7, 32'd14, 33);
        repeat (5) @(negedge clk);
        start = 1'b1; op = MUL; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign");
        repeat (40) @(negedge clk);
        check("ign_hold", {32'h0, result}, 64'd14);
        check("ign_idle", {63'h0, busy}, 64'h0);

        // Back-to-back: second start coincides with valid
        issue("b2b_first", MUL, 32'd12, 32'd11, 32'd132, 33);
        n = 0;
        while (!valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        begin
            exp_t e;
            start = 1'b1; op = REMU; a = 32'd100; b = 32'd7;
            e.name = "b2b_second"; e.res = 32'd2; e.t0 = cyc + 1; e.lat = 33;
            exp_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
        end
        wait_done("b2b");

        // Reset mid-operation
        issue("rst_mid", MUL, 32'd9, 32'd9, 32'd81, 33);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rstmid_busy", {63'h0, busy}, 64'h0);
        check("rstmid_valid", {63'h0, valid}, 64'h0);
        check("rstmid_result", {32'h0, result}, 64'h0);
        exp_q.delete();
        rstn = 1'b1;
        issue("post_rst", DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);           wait_done("post_rst");

        // XLEN=8 instance
        issue8("mul8", MUL, 8'd7, 8'hFD, 8'hEB, 9);                                  wait_done("mul8");
        issue8("mulh8", MULH, 8'h80, 8'hFF, 8'h00, 9);                               wait_done("mulh8");
        issue8("mulhu8", MULHU, 8'h80, 8'hFF, 8'h7F, 9);                             wait_done("mulhu8");
        issue8("div8", DIV, 8'hF9, 8'd2, 8'hFD, 9);                                  wait_done("div8");
        issue8("rem8", REM, 8'hF9, 8'd2, 8'hFF, 9);                                  wait_done("rem8");
        issue8("divu8", DIVU, 8'hFF, 8'd16, 8'h0F, 9);                               wait_done("divu8");
        issue8("remu8", REMU, 8'hFF, 8'd16, 8'h0F, 9);                               wait_done("remu8");
        issue8("divovf8", DIV, 8'h80, 8'hFF, 8'h80, SpecLat8);                       wait_done("divovf8");
        issue8("remuz8", REMU, 8'd5, 8'd0, 8'd5, SpecLat8);                          wait_done("remuz8");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
